// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned mul/div unit beside the Execute stage.
// Stalls F/D/E while busy and emits a one-cycle DoneW pulse with the result.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   StartE, OpE            E-stage mul/div request and op (MUL/UMULH/UDIV/UREM)
//   SrcAE, SrcBE           operands (A = multiplicand/dividend, B = multiplier/divisor)
//   WA3E                   destination register of the E-stage op
//   FlushE                 aborts any in-flight op
//   BusyStall              stall request to the hazard unit
//   DoneW                  result-valid pulse
//   ResultOut, WA3Out      result and its destination register
module muldiv_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        StartE,
   input  logic [1:0]  OpE,
   input  logic [31:0] SrcAE,
   input  logic [31:0] SrcBE,
   input  logic [3:0]  WA3E,
   input  logic        FlushE,
   output logic        BusyStall,
   output logic        DoneW,
   output logic [31:0] ResultOut,
   output logic [3:0]  WA3Out
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [4:0]  cnt;
   logic [1:0]  op_q;
   logic [3:0]  wa3_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] hi_nx;
   logic [31:0] lo_nx;
   logic [32:0] sum;
   logic [32:0] shl;
   logic [32:0] diff;
   logic        busy;
   logic        accept;
   logic        div_zero;
   logic        last;

   assign div_zero = OpE[1] && (SrcBE == 32'd0);
   assign accept   = (state == IDLE) && StartE && !FlushE;
   assign last     = (state == RUN) && !FlushE && (cnt == 5'd31);

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      unique case (state)
         IDLE: begin
            if (StartE && !FlushE) begin
               busy     = 1'b1;
               state_nx = div_zero ? DONE : RUN;
            end
         end
         RUN: begin
            if (FlushE) begin
               state_nx = IDLE;
            end else begin
               busy = 1'b1;
               if (cnt == 5'd31) begin
                  state_nx = DONE;
               end
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
      BusyStall = busy && !reset;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   assign DoneW = (state == DONE);

   // {hi,lo} is the working register pair: for multiply it is the
   // 64-bit product shifting right with the multiplier consumed from lo;
   // for divide hi is the partial remainder and lo shifts the dividend
   // out while quotient bits shift in.
   always_comb begin
      sum  = lo[0] ? ({1'b0, hi} + {1'b0, a_q}) : {1'b0, hi};
      shl  = {hi, lo[31]};
      diff = shl - {1'b0, b_q};
      if (op_q[1]) begin
         if (!diff[32]) begin
            hi_nx = diff[31:0];
            lo_nx = {lo[30:0], 1'b1};
         end else begin
            hi_nx = shl[31:0];
            lo_nx = {lo[30:0], 1'b0};
         end
      end else begin
         hi_nx = sum[32:1];
         lo_nx = {sum[0], lo[31:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= 5'd0;
         op_q      <= 2'd0;
         wa3_q     <= 4'd0;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         hi        <= 32'd0;
         lo        <= 32'd0;
         ResultOut <= 32'd0;
         WA3Out    <= 4'd0;
      end else if (accept) begin
         if (div_zero) begin
            ResultOut <= OpE[0] ? SrcAE : 32'hFFFF_FFFF;
            WA3Out    <= WA3E;
         end else begin
            op_q  <= OpE;
            wa3_q <= WA3E;
            a_q   <= SrcAE;
            b_q   <= SrcBE;
            cnt   <= 5'd0;
            hi    <= 32'd0;
            lo    <= OpE[1] ? SrcAE : SrcBE;
         end
      end else if (state == RUN) begin
         if (FlushE) begin
            cnt <= 5'd0;
         end else begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            cnt <= cnt + 5'd1;
            if (last) begin
               ResultOut <= op_q[0] ? hi_nx : lo_nx;
               WA3Out    <= wa3_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer.
// Hand-computed vectors for mul/div, divide-by-zero, flush and reset abort.
module tb_muldiv_sequencer;

   logic        clk;
   logic        reset;
   logic        StartE;
   logic [1:0]  OpE;
   logic [31:0] SrcAE;
   logic [31:0] SrcBE;
   logic [3:0]  WA3E;
   logic        FlushE;
   logic        BusyStall;
   logic        DoneW;
   logic [31:0] ResultOut;
   logic [3:0]  WA3Out;

   int errors = 0;
   int checks = 0;

   muldiv_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .StartE    (StartE),
      .OpE       (OpE),
      .SrcAE     (SrcAE),
      .SrcBE     (SrcBE),
      .WA3E      (WA3E),
      .FlushE    (FlushE),
      .BusyStall (BusyStall),
      .DoneW     (DoneW),
      .ResultOut (ResultOut),
      .WA3Out    (WA3Out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called just after a rising edge; returns just after a rising edge.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] wa,
                         input logic [31:0] exp_r, input int exp_lat,
                         input string name);
      int cyc;
      int busy;
      bit seen;
      OpE    = op;
      SrcAE  = a;
      SrcBE  = b;
      WA3E   = wa;
      StartE = 1'b1;
      FlushE = 1'b0;
      cyc  = 0;
      busy = 0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (DoneW) begin
            seen = 1;
            break;
         end
         if (BusyStall) busy++;
         cyc++;
         @(posedge clk);
         #1;
         SrcAE = $urandom;
         SrcBE = $urandom;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s timeout: no DoneW within 40 cycles", name);
      end
      checks++;
      if (cyc !== exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
      end
      checks++;
      if (busy !== exp_lat) begin
         errors++;
         $display("FAIL %s busy cycles: got %0d want %0d", name, busy, exp_lat);
      end
      checks++;
      if (ResultOut !== exp_r) begin
         errors++;
         $display("FAIL %s result: got %h want %h", name, ResultOut, exp_r);
      end
      checks++;
      if (WA3Out !== wa) begin
         errors++;
         $display("FAIL %s WA3Out: got %h want %h", name, WA3Out, wa);
      end
      checks++;
      if (BusyStall !== 1'b0) begin
         errors++;
         $display("FAIL %s busy in DONE: got %b want 0", name, BusyStall);
      end
      // StartE was held high through DONE; it must not restart.
      @(posedge clk);
      #1;
      StartE = 1'b0;
      @(negedge clk);
      checks++;
      if (DoneW !== 1'b0 || BusyStall !== 1'b0) begin
         errors++;
         $display("FAIL %s after DONE: got DoneW=%b Busy=%b want 0 0",
                  name, DoneW, BusyStall);
      end
      checks++;
      if (ResultOut !== exp_r) begin
         errors++;
         $display("FAIL %s result hold: got %h want %h", name, ResultOut, exp_r);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic no_done_scan(input int n, input string name);
      int dw;
      dw = 0;
      repeat (n) begin
         @(negedge clk);
         if (DoneW) dw++;
      end
      checks++;
      if (dw != 0) begin
         errors++;
         $display("FAIL %s stray DoneW: got %0d pulses want 0", name, dw);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      StartE = 1'b1;
      FlushE = 1'b0;
      OpE    = 2'b00;
      SrcAE  = 32'd3;
      SrcBE  = 32'd5;
      WA3E   = 4'd1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (BusyStall !== 1'b0) begin
         errors++;
         $display("FAIL reset busy: got %b want 0", BusyStall);
      end
      checks++;
      if (DoneW !== 1'b0) begin
         errors++;
         $display("FAIL reset DoneW: got %b want 0", DoneW);
      end
      checks++;
      if (ResultOut !== 32'd0) begin
         errors++;
         $display("FAIL reset result: got %h want 0", ResultOut);
      end
      checks++;
      if (WA3Out !== 4'd0) begin
         errors++;
         $display("FAIL reset WA3Out: got %h want 0", WA3Out);
      end
      @(posedge clk);
      #1;
      reset  = 1'b0;
      StartE = 1'b0;
      @(negedge clk);
      checks++;
      if (BusyStall !== 1'b0 || DoneW !== 1'b0) begin
         errors++;
         $display("FAIL idle after reset: got Busy=%b DoneW=%b want 0 0",
                  BusyStall, DoneW);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_mul();
      run_op(2'b00, 32'h0001_0003, 32'h0000_0005, 4'd4, 32'h0005_000F, 33, "mul_small");
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 32'h0000_0001, 33, "mul_ff");
   endtask

   task automatic test_umulh();
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7, 32'hFFFF_FFFE, 33, "umulh_ff");
      run_op(2'b01, 32'h8000_0000, 32'h0000_0004, 4'd8, 32'h0000_0002, 33, "umulh_shift");
   endtask

   task automatic test_div();
      run_op(2'b10, 32'd100, 32'd7, 4'd3, 32'd14, 33, "udiv_100_7");
      run_op(2'b11, 32'd100, 32'd7, 4'd5, 32'd2, 33, "urem_100_7");
      run_op(2'b10, 32'hFFFF_FFFF, 32'h0000_0010, 4'd10, 32'h0FFF_FFFF, 33, "udiv_big");
      run_op(2'b10, 32'd5, 32'hFFFF_FFF0, 4'd11, 32'd0, 33, "udiv_small_big");
   endtask

   task automatic test_div_zero();
      run_op(2'b10, 32'd5, 32'd0, 4'd12, 32'hFFFF_FFFF, 1, "udiv_zero");
      run_op(2'b11, 32'd5, 32'd0, 4'd13, 32'd5, 1, "urem_zero");
   endtask

   task automatic test_flush();
      OpE    = 2'b00;
      SrcAE  = 32'd3;
      SrcBE  = 32'd5;
      WA3E   = 4'd2;
      StartE = 1'b1;
      FlushE = 1'b0;
      @(posedge clk);
      repeat (9) @(posedge clk);
      #1;
      FlushE = 1'b1;
      @(negedge clk);
      checks++;
      if (BusyStall !== 1'b0 || DoneW !== 1'b0) begin
         errors++;
         $display("FAIL flush cycle: got Busy=%b DoneW=%b want 0 0",
                  BusyStall, DoneW);
      end
      @(posedge clk);
      #1;
      FlushE = 1'b0;
      StartE = 1'b0;
      @(negedge clk);
      checks++;
      if (BusyStall !== 1'b0 || DoneW !== 1'b0) begin
         errors++;
         $display("FAIL after flush: got Busy=%b DoneW=%b want 0 0",
                  BusyStall, DoneW);
      end
      @(posedge clk);
      #1;
      run_op(2'b00, 32'd7, 32'd6, 4'd9, 32'd42, 33, "mul_after_flush");
      FlushE = 1'b1;
      StartE = 1'b1;
      @(negedge clk);
      checks++;
      if (BusyStall !== 1'b0) begin
         errors++;
         $display("FAIL flush in IDLE busy: got %b want 0", BusyStall);
      end
      @(posedge clk);
      #1;
      StartE = 1'b0;
      FlushE = 1'b0;
      no_done_scan(36, "flush_idle");
   endtask

   task automatic test_reset_mid_run();
      OpE    = 2'b00;
      SrcAE  = 32'h1234_5678;
      SrcBE  = 32'd3;
      WA3E   = 4'd14;
      StartE = 1'b1;
      FlushE = 1'b0;
      @(posedge clk);
      repeat (19) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (BusyStall !== 1'b0) begin
         errors++;
         $display("FAIL reset mid-run busy: got %b want 0", BusyStall);
      end
      @(posedge clk);
      #1;
      reset  = 1'b0;
      StartE = 1'b0;
      @(negedge clk);
      checks++;
      if (DoneW !== 1'b0 || ResultOut !== 32'd0 || WA3Out !== 4'd0) begin
         errors++;
         $display("FAIL reset mid-run outputs: got DoneW=%b res=%h wa=%h want 0 0 0",
                  DoneW, ResultOut, WA3Out);
      end
      @(posedge clk);
      #1;
      no_done_scan(20, "reset_mid_run");
      run_op(2'b11, 32'd23, 32'd5, 4'd15, 32'd3, 33, "urem_after_reset");
   endtask

   task automatic test_back_to_back();
      run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 4'd1, 32'h0000_000F, 33, "b2b_urem");
      run_op(2'b00, 32'h0000_1234, 32'h0000_0010, 4'd2, 32'h0001_2340, 33, "b2b_mul");
   endtask

   initial begin
      test_reset();
      test_mul();
      test_umulh();
      test_div();
      test_div_zero();
      test_flush();
      test_reset_mid_run();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
